dog_sprite_fetch: RTL

DOG_SPRITE_FETCH -- requirements
Module: dog_sprite_fetch

---
 rtl/dog_sprite_fetch_if.sv | 32 +++
 rtl/dog_sprite_fetch.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dog_sprite_fetch_if.sv
// Signal bundle between the video timing / sprite controller side and the
// sprite fetch pipeline: pixel position, sprite placement, animation control,
// the sprite ROM port and the palette-index result.
interface dog_sprite_fetch_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        active;
    logic [9:0]  dog_x;
    logic [9:0]  dog_y;
    logic        flip_x;
    logic        anim_en;
    logic        frame_tick;
    logic [12:0] rom_addr;
    logic [3:0]  rom_q;
    logic [3:0]  pixel_index;
    logic [2:0]  frame_sel;
    logic        dog_on;

    // Video/controller side: presents pixels, owns the ROM, consumes indices.
    modport master (
        output DrawX, DrawY, active, dog_x, dog_y, flip_x, anim_en, frame_tick,
        output rom_q,
        input  rom_addr, pixel_index, frame_sel, dog_on
    );

    // Fetch pipeline side.
    modport slave (
        input  DrawX, DrawY, active, dog_x, dog_y, flip_x, anim_en, frame_tick,
        input  rom_q,
        output rom_addr, pixel_index, frame_sel, dog_on
    );
endinterface

// File: rtl/dog_sprite_fetch.sv
// Three-stage sprite fetch: in-box test and ROM address generation, ROM
// read alignment, then palette index / frame select / sprite-on output.
// Also owns the animation frame counter, stepped every FRAME_DIV ticks.
module dog_sprite_fetch #(
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int NUM_FRAMES = 6,
    parameter int FRAME_DIV  = 8
) (
    input logic              Clk,
    input logic              Reset,
    dog_sprite_fetch_if.slave bus
);

    localparam int SX_W  = $clog2(SPRITE_W);
    localparam int SY_W  = $clog2(SPRITE_H);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(FRAME_DIV - 1);
    localparam logic [2:0]       FRAME_MAX = 3'(NUM_FRAMES - 1);

    logic [2:0]       frame;
    logic [DIV_W-1:0] div_cnt;
    logic             step_tick;

    logic [10:0]      x_ext, y_ext, dx_ext, dy_ext;
    logic             in_x, in_y, in_box;
    logic [SX_W-1:0]  x_off, sx;
    logic [SY_W-1:0]  sy;
    logic [12:0]      addr_c;

    logic [12:0]      rom_addr_p0;
    logic             vld_p0;
    logic [2:0]       frame_p0;
    logic             vld_p1;
    logic [2:0]       frame_p1;
    logic [3:0]       pix_p2;
    logic [2:0]       frame_p2;
    logic             vld_p2;

    assign step_tick = bus.frame_tick & bus.anim_en;

    // Animation divider and frame counter; stage 1 samples the old frame on
    // the tick cycle, so pixels already in flight keep their frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_cnt <= '0;
            frame   <= '0;
        end else if (step_tick) begin
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
                frame   <= (frame == FRAME_MAX) ? 3'd0 : frame + 3'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Box test in 11 bits so a sprite hanging past the right/bottom edge
    // never wraps back onto column/row 0.
    assign x_ext  = {1'b0, bus.DrawX};
    assign y_ext  = {1'b0, bus.DrawY};
    assign dx_ext = {1'b0, bus.dog_x};
    assign dy_ext = {1'b0, bus.dog_y};
    assign in_x   = (x_ext >= dx_ext) && (x_ext < dx_ext + 11'(SPRITE_W));
    assign in_y   = (y_ext >= dy_ext) && (y_ext < dy_ext + 11'(SPRITE_H));
    assign in_box = bus.active & in_x & in_y;

    // Offsets only need the low bits once the box test has passed; with a
    // power-of-two width, SPRITE_W-1-off is the bitwise complement.
    assign x_off = SX_W'(bus.DrawX - bus.dog_x);
    assign sx    = bus.flip_x ? ~x_off : x_off;
    assign sy    = SY_W'(bus.DrawY - bus.dog_y);

    assign addr_c = in_box ? ((13'(frame) << (SX_W + SY_W)) | (13'(sy) << SX_W) | 13'(sx))
                           : 13'd0;

    // Stage 1: ROM address, in-box flag and frame captured with the pixel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_p0 <= '0;
            vld_p0      <= 1'b0;
            frame_p0    <= '0;
        end else begin
            rom_addr_p0 <= addr_c;
            vld_p0      <= in_box;
            frame_p0    <= frame;
        end
    end

    // Stage 2: hold flag and frame while the ROM read completes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_p1   <= 1'b0;
            frame_p1 <= '0;
        end else begin
            vld_p1   <= vld_p0;
            frame_p1 <= frame_p0;
        end
    end

    // Stage 3: register the palette index, masked to 0 outside the sprite box.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_p2   <= '0;
            frame_p2 <= '0;
            vld_p2   <= 1'b0;
        end else begin
            pix_p2   <= vld_p1 ? bus.rom_q : 4'd0;
            frame_p2 <= frame_p1;
            vld_p2   <= vld_p1;
        end
    end

    assign bus.rom_addr    = rom_addr_p0;
    assign bus.pixel_index = pix_p2;
    assign bus.frame_sel   = frame_p2;
    assign bus.dog_on      = vld_p2;

endmodule
